// File: rtl/dsel_stepper_pkg.sv
// dsel_stepper_pkg
//   Constants shared by the front-panel display-select logic:
//   - one-hot display-select codes as decoded by the front-panel data mux,
//   - the debounce FSM state encoding,
//   - a one-hot test helper.
//   No ports; imported by dsel_stepper and fp_sync2.
package dsel_stepper_pkg;

    localparam logic [5:0] DSEL_STATE  = 6'b100000;
    localparam logic [5:0] DSEL_STATUS = 6'b010000;
    localparam logic [5:0] DSEL_AC     = 6'b001000;
    localparam logic [5:0] DSEL_MB     = 6'b000100;
    localparam logic [5:0] DSEL_MQ     = 6'b000010;
    localparam logic [5:0] DSEL_BUS    = 6'b000001;
    localparam logic [5:0] DSEL_RESET  = DSEL_STATE;

    typedef enum logic [1:0] {
        ST_RELEASED     = 2'd0,
        ST_PRESS_WAIT   = 2'd1,
        ST_HELD         = 2'd2,
        ST_RELEASE_WAIT = 2'd3
    } btn_state_t;

    function automatic logic is_onehot6(input logic [5:0] v);
        logic [2:0] ones;
        ones = '0;
        for (int i = 0; i < 6; i++) begin
            ones = ones + {2'b00, v[i]};
        end
        return (ones == 3'd1);
    endfunction

endpackage

// File: rtl/dsel_stepper_fp_sync2.sv
// fp_sync2
//   Two-flop synchronizer for one asynchronous front-panel input. Reusable
//   for any of the panel switches.
// Ports
//   clk    in  1  system clock
//   reset  in  1  synchronous, active-high; clears both flops
//   d      in  1  asynchronous input
//   q      out 1  synchronized output, two clk edges behind d
module fp_sync2 (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (reset) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/dsel_stepper.sv
// dsel_stepper
//   Front-panel display-select sequencer. Debounces the DISP push-button and
//   rotates a one-hot select STATE -> STATUS -> AC -> MB -> MQ -> BUS -> STATE
//   once per accepted press. The dsel output drives the data mux.
//   Optional feature macro: DSEL_AUTOSCAN_EN adds the autoscan_on port and a
//   timer that advances dsel every AUTOSCAN_CYCLES cycles.
// Ports
//   clk          in  1  system clock
//   reset        in  1  synchronous, active-high
//   btn_raw      in  1  DISP button, asynchronous, active-high, bouncy
//   lock         in  1  panel key lock; 1 = hold dsel, ignore button/autoscan
//   autoscan_on  in  1  enable auto-advance (only with DSEL_AUTOSCAN_EN)
//   dsel         out 6  one-hot display select
//   step_pulse   out 1  one-cycle strobe on every dsel advance
module dsel_stepper
    import dsel_stepper_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CNT_W           = 16,
    parameter int AUTOSCAN_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_raw,
    input  logic       lock,
`ifdef DSEL_AUTOSCAN_EN
    input  logic       autoscan_on,
`endif
    output logic [5:0] dsel,
    output logic       step_pulse
);

    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             btn_s;
    btn_state_t       state;
    logic [CNT_W-1:0] cnt;
    logic             btn_hit;
    logic             scan_hit;
    logic             do_step;

    fp_sync2 u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (btn_raw),
        .q     (btn_s)
    );

    // Debounce FSM. The counter only advances while it is below DB_LAST and
    // every state leaving or reaching DB_LAST resets it, so it never wraps.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_RELEASED;
            cnt   <= '0;
        end else begin
            case (state)
                ST_RELEASED: begin
                    if (btn_s) begin
                        state <= ST_PRESS_WAIT;
                        cnt   <= '0;
                    end
                end
                ST_PRESS_WAIT: begin
                    if (!btn_s) begin
                        state <= ST_RELEASED;
                        cnt   <= '0;
                    end else if (cnt == DB_LAST) begin
                        state <= ST_HELD;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                ST_HELD: begin
                    if (!btn_s) begin
                        state <= ST_RELEASE_WAIT;
                        cnt   <= '0;
                    end
                end
                ST_RELEASE_WAIT: begin
                    if (btn_s) begin
                        state <= ST_HELD;
                        cnt   <= '0;
                    end else if (cnt == DB_LAST) begin
                        state <= ST_RELEASED;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state <= ST_RELEASED;
                    cnt   <= '0;
                end
            endcase
        end
    end

    // The press is accepted on the same edge that enters HELD; the lock only
    // masks the step, the FSM keeps tracking the button.
    assign btn_hit = (state == ST_PRESS_WAIT) && btn_s && (cnt == DB_LAST);

`ifdef DSEL_AUTOSCAN_EN
    localparam logic [CNT_W-1:0] SCAN_LAST = CNT_W'(AUTOSCAN_CYCLES - 1);

    logic [CNT_W-1:0] scan_cnt;

    assign scan_hit = autoscan_on && !lock && (scan_cnt == SCAN_LAST);

    always_ff @(posedge clk) begin
        if (reset || !autoscan_on || lock || scan_hit) begin
            scan_cnt <= '0;
        end else begin
            scan_cnt <= scan_cnt + CNT_W'(1);
        end
    end
`else
    assign scan_hit = 1'b0;

    // AUTOSCAN_CYCLES only sizes the scan timer, which this build omits.
    if (AUTOSCAN_CYCLES < 1) begin : g_no_autoscan
    end
`endif

    // Button and timer hits on the same edge merge into a single rotate.
    assign do_step = (btn_hit && !lock) || scan_hit;

    always_ff @(posedge clk) begin
        if (reset) begin
            dsel       <= DSEL_RESET;
            step_pulse <= 1'b0;
        end else if (!is_onehot6(dsel)) begin
            dsel       <= DSEL_RESET;
            step_pulse <= 1'b0;
        end else if (do_step) begin
            dsel       <= {dsel[0], dsel[5:1]};
            step_pulse <= 1'b1;
        end else begin
            step_pulse <= 1'b0;
        end
    end

endmodule

// File: tb/tb_dsel_stepper.sv
// tb_dsel_stepper
//   Self-checking bench for dsel_stepper with DEBOUNCE_CYCLES=4 and
//   AUTOSCAN_CYCLES=8. Every observed step_pulse is matched against a queue
//   of expected dsel values; a table of press patterns plus a few hand-written
//   sequences drive the button, lock and (with DSEL_AUTOSCAN_EN) autoscan.
module tb_dsel_stepper;

    logic       clk;
    logic       reset;
    logic       btn_raw;
    logic       lock;
    logic       autoscan_on;
    logic [5:0] dsel;
    logic       step_pulse;

    int checks = 0;
    int errors = 0;

    logic [5:0] exp_q[$];
    logic [5:0] mon_exp;
    bit         mon_en = 1'b0;

    typedef struct {
        int         high;
        int         low;
        bit         lck;
        logic [5:0] exp_dsel;
        bit         exp_step;
    } press_vec_t;

    press_vec_t vecs[10];

    dsel_stepper #(
        .DEBOUNCE_CYCLES (4),
        .CNT_W           (16),
        .AUTOSCAN_CYCLES (8)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .btn_raw     (btn_raw),
        .lock        (lock),
`ifdef DSEL_AUTOSCAN_EN
        .autoscan_on (autoscan_on),
`endif
        .dsel        (dsel),
        .step_pulse  (step_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard: each pulse consumes one expected dsel value.
    always @(negedge clk) begin
        if (mon_en && step_pulse === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_step dsel=%b required=no step", dsel);
            end else begin
                mon_exp = exp_q.pop_front();
                if (dsel !== mon_exp) begin
                    errors++;
                    $display("FAIL step_dsel actual=%b required=%b", dsel, mon_exp);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [5:0] act, input logic [5:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%b required=%b", name, act, req);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        cycles(n);
        reset = 1'b0;
    endtask

    initial begin
        reset       = 1'b1;
        btn_raw     = 1'b0;
        lock        = 1'b0;
        autoscan_on = 1'b0;

        vecs[0] = '{10, 10, 1'b0, 6'b010000, 1'b1};
        vecs[1] = '{10, 10, 1'b0, 6'b001000, 1'b1};
        vecs[2] = '{10, 10, 1'b0, 6'b000100, 1'b1};
        vecs[3] = '{10, 10, 1'b0, 6'b000010, 1'b1};
        vecs[4] = '{10, 10, 1'b0, 6'b000001, 1'b1};
        vecs[5] = '{10, 10, 1'b0, 6'b100000, 1'b1};
        vecs[6] = '{ 2,  3, 1'b0, 6'b100000, 1'b0};
        vecs[7] = '{ 2,  3, 1'b0, 6'b100000, 1'b0};
        vecs[8] = '{10, 10, 1'b1, 6'b100000, 1'b0};
        vecs[9] = '{10, 10, 1'b0, 6'b010000, 1'b1};

        // Reset state and idle.
        cycles(3);
        chk("reset_dsel", dsel, 6'b100000);
        chk("reset_pulse", {5'b0, step_pulse}, 6'b000000);
        reset  = 1'b0;
        mon_en = 1'b1;
        cycles(20);
        chk("idle_dsel", dsel, 6'b100000);

        // Held button: pulse exactly 6 edges after the first sampling edge.
        exp_q.push_back(6'b010000);
        btn_raw = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk($sformatf("latency_pulse_k%0d", k), {5'b0, step_pulse},
                (k == 6) ? 6'b000001 : 6'b000000);
        end
        cycles(10);
        chk("held_no_repeat", dsel, 6'b010000);
        btn_raw = 1'b0;
        cycles(10);
        do_reset(3);
        chk("reset_again", dsel, 6'b100000);

        // Table: clean presses, glitches, locked press, unlocked press.
        for (int i = 0; i < 10; i++) begin
            if (vecs[i].exp_step) exp_q.push_back(vecs[i].exp_dsel);
            lock    = vecs[i].lck;
            btn_raw = 1'b1;
            cycles(vecs[i].high);
            btn_raw = 1'b0;
            cycles(vecs[i].low);
            lock = 1'b0;
            cycles(8);
            chk($sformatf("vec%0d_dsel", i), dsel, vecs[i].exp_dsel);
        end

        // Release bounce inside HELD gives no second step.
        exp_q.push_back(6'b001000);
        btn_raw = 1'b1;
        cycles(10);
        btn_raw = 1'b0;
        cycles(2);
        btn_raw = 1'b1;
        cycles(10);
        btn_raw = 1'b0;
        cycles(12);
        chk("bounce_dsel", dsel, 6'b001000);

        // Lock released while HELD does not step.
        lock    = 1'b1;
        btn_raw = 1'b1;
        cycles(10);
        lock = 1'b0;
        cycles(6);
        btn_raw = 1'b0;
        cycles(12);
        chk("unlock_in_held", dsel, 6'b001000);

        // Reset mid-press aborts it; no step afterwards.
        btn_raw = 1'b1;
        cycles(4);
        reset   = 1'b1;
        btn_raw = 1'b0;
        cycles(3);
        reset = 1'b0;
        cycles(20);
        chk("reset_midpress_dsel", dsel, 6'b100000);

`ifdef DSEL_AUTOSCAN_EN
        // Autoscan every 8 cycles; a press landing on a timer step gives one step.
        exp_q.push_back(6'b010000);
        exp_q.push_back(6'b001000);
        exp_q.push_back(6'b000100);
        exp_q.push_back(6'b000010);
        exp_q.push_back(6'b000001);
        autoscan_on = 1'b1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            chk($sformatf("scan_pulse_k%0d", k), {5'b0, step_pulse},
                ((k % 8) == 7) ? 6'b000001 : 6'b000000);
            if (k == 24) btn_raw = 1'b1;
        end
        autoscan_on = 1'b0;
        btn_raw     = 1'b0;
        cycles(20);
        chk("scan_end_dsel", dsel, 6'b000001);

        // Locked autoscan holds.
        lock        = 1'b1;
        autoscan_on = 1'b1;
        cycles(20);
        chk("scan_locked_dsel", dsel, 6'b000001);
        lock        = 1'b0;
        autoscan_on = 1'b0;
        cycles(2);
`endif

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL missing_steps actual=%0d pending required=0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
